prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Parametrised successor to the fixed program memory. Holds a DEPTH-entry program of {opcode, operand} words.
- Owns its own program counter and issues one instruction per accepted valid/ready handshake to the accumulator datapath.
- Runs from a start pulse to the final instruction, then pulses done. Supports abort.
- Operand constants and program length are parameters, not hard-coded.

Parameters:
- ADDR_W, 4, program counter / address width.
- OP_W, 3, opcode width.
- VAL_W, 4, operand width.
- DEPTH, 7, number of program entries in use; 1 <= DEPTH <= 2**ADDR_W.
- CONST_A, 4, operand constant A.
- CONST_C, 2, operand constant C.
- CONST_D, 1, operand constant D.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to run the program from address 0.
- abort  in  1  cancel the run in progress.
- instr_valid  out  1  instr_op/instr_val hold a valid instruction.
- instr_ready  in  1  datapath accepts the instruction this cycle.
- instr_op  out  OP_W  opcode: 0 clrld, 1 addld, 2 add, 3 div2, 4 disp, 7 nop.
- instr_val  out  VAL_W  operand.
- pc  out  ADDR_W  address of the instruction currently presented.
- busy  out  1  high in ISSUE state.
- done  out  1  one-cycle pulse after the last instruction is accepted.

Behaviour:
- Default program, entries 0..6:
  - 0: clrld CONST_A
  - 1: addld CONST_C
  - 2: addld CONST_A
  - 3: addld CONST_C
  - 4: add CONST_D
  - 5: div2 0
  - 6: disp 0
- Entries >= 7 and < DEPTH read as {nop, 0}. Operands are truncated to VAL_W.
- Reset (rst_n low at a clock edge), overriding all other inputs:
  - state=IDLE.
  - pc=0, instr_valid=0, instr_op=0, instr_val=0, busy=0, done=0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - start=1 -> ISSUE.
  - Next cycle: pc=0, instr_valid=1, entry 0 presented, busy=1.
  - Latency from start to first valid is one cycle.
- ISSUE:
  - The outputs are registered and held stable while instr_valid=1 and instr_ready=0.
  - Handshake (instr_valid & instr_ready) with pc < DEPTH-1: pc increments and the next entry is presented the following cycle with instr_valid still 1. Back-to-back issue is one instruction per cycle.
  - Handshake with pc == DEPTH-1 -> DONE: instr_valid=0 and done=1 for exactly one cycle.
- DONE: unconditionally -> IDLE. done=0, busy=0, pc held at DEPTH-1.
- abort=1 in ISSUE -> IDLE next cycle:
  - instr_valid=0, busy=0, no done pulse.
  - A handshake in the same cycle is still counted by the datapath; abort wins for state.
- start while in ISSUE or DONE is ignored; no restart and no queueing.
- start and abort together in IDLE: abort wins, stay IDLE.
- pc never wraps; pc increments only inside ISSUE.

Optional Feature:
- Macro PROG_WR_EN.
- Defined:
  - Storage is writable. Adds ports prog_we (in, 1), prog_addr (in, ADDR_W), prog_op (in, OP_W), prog_val (in, VAL_W).
  - A write occurs at a clock edge when prog_we=1, state=IDLE and prog_addr < DEPTH.
  - The written entry is visible to the next run.
  - Writes while busy, or to addresses >= DEPTH, are dropped.
  - Reset does not alter storage contents; it powers up with the default program.
- Not defined: storage is constant, write ports are absent, and prog_sequencer is pure ROM plus sequencer.

Test Plan:
- Reset then start with instr_ready=1 constantly -> 7 consecutive valid cycles (op,val) = (0,4),(1,2),(1,4),(1,2),(2,1),(3,0),(4,0), then done=1 for one cycle, then busy=0.
- Start with instr_ready toggling 1,0,1,0 -> every instruction held stable across ready=0 cycles; each is issued exactly once; done appears after the 7th handshake.
- abort asserted at pc=3 while instr_valid=1 -> IDLE next cycle, instr_valid=0, no done. A following start restarts at pc=0 with (0,4).
- start pulsed again at pc=2 -> ignored: sequence continues to pc=3 and no restart occurs.
- rst_n low at pc=5 -> next cycle all outputs 0 and state IDLE. start afterwards runs from pc=0.
- With PROG_WR_EN: in IDLE write addr 4 = (2,7); start -> the 5th issued instruction is (2,7). A write attempted while busy leaves the entry unchanged on the next run.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: DEPTH-entry {op,val} store, issues one instr per valid/ready handshake; start->first valid 1 cycle.
// Outputs registered and held while instr_ready=0; optional writable storage via PROG_WR_EN.
module prog_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int OP_W    = 3,
  parameter int VAL_W   = 4,
  parameter int DEPTH   = 7,
  parameter int CONST_A = 4,
  parameter int CONST_C = 2,
  parameter int CONST_D = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
`ifdef PROG_WR_EN
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [OP_W-1:0]   prog_op,
  input  logic [VAL_W-1:0]  prog_val,
`endif
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [OP_W-1:0]   instr_op,
  output logic [VAL_W-1:0]  instr_val,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int WORD_W = OP_W + VAL_W;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [VAL_W-1:0]    val_q, val_d;
  logic [WORD_W-1:0]   first_word, next_word;

  function automatic logic [WORD_W-1:0] rom_word(input int a);
    case (a)
      0:       return {OP_W'(0), VAL_W'(CONST_A)};
      1:       return {OP_W'(1), VAL_W'(CONST_C)};
      2:       return {OP_W'(1), VAL_W'(CONST_A)};
      3:       return {OP_W'(1), VAL_W'(CONST_C)};
      4:       return {OP_W'(2), VAL_W'(CONST_D)};
      5:       return {OP_W'(3), VAL_W'(0)};
      6:       return {OP_W'(4), VAL_W'(0)};
      default: return {OP_W'(7), VAL_W'(0)};
    endcase
  endfunction

`ifdef PROG_WR_EN
  function automatic logic [DEPTH*WORD_W-1:0] default_image();
    logic [DEPTH*WORD_W-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) img[i*WORD_W +: WORD_W] = rom_word(i);
    return img;
  endfunction

  // Storage is never reset: it powers up holding the default program and keeps writes across resets.
  logic [DEPTH-1:0][WORD_W-1:0] mem_q = default_image();
  logic                         wr_en;

  assign wr_en = prog_we && (state_q == S_IDLE) &&
                 ({1'b0, prog_addr} < (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (prog_addr == ADDR_W'(i))) mem_q[i] <= {prog_op, prog_val};
    end
  end

  function automatic logic [WORD_W-1:0] fetch(input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] w;
    w = {OP_W'(7), VAL_W'(0)};
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) w = mem_q[i];
    end
    return w;
  endfunction
`else
  function automatic logic [WORD_W-1:0] fetch(input logic [ADDR_W-1:0] a);
    return rom_word(int'(a));
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    op_d       = op_q;
    val_d      = val_q;
    first_word = fetch('0);
    next_word  = fetch(pc_q + ADDR_W'(1));
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d        = S_ISSUE;
          pc_d           = '0;
          valid_d        = 1'b1;
          {op_d, val_d}  = first_word;
        end
      end
      S_ISSUE: begin
        // Abort takes priority over a same-cycle handshake for state purposes.
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (valid_q && instr_ready) begin
          if (pc_q == LAST_PC) begin
            state_d = S_DONE;
            valid_d = 1'b0;
          end else begin
            pc_d          = pc_q + ADDR_W'(1);
            {op_d, val_d} = next_word;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_valid = valid_q;
  assign instr_op    = op_q;
  assign instr_val   = val_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: per-cycle vector table plus an issued-instruction scoreboard.
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, instr_ready;
  logic       instr_valid, busy, done;
  logic [2:0] instr_op;
  logic [3:0] instr_val, pc;
`ifdef PROG_WR_EN
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [2:0] prog_op;
  logic [3:0] prog_val;
`endif

  always #5 clk = ~clk;

  prog_sequencer #(
    .ADDR_W(4), .OP_W(3), .VAL_W(4), .DEPTH(7),
    .CONST_A(4), .CONST_C(2), .CONST_D(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef PROG_WR_EN
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op), .prog_val(prog_val),
`endif
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_val(instr_val), .pc(pc),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic       rst_n, start, abort, ready;
    logic       we;
    logic [3:0] wa;
    logic [2:0] wop;
    logic [3:0] wval;
    logic       valid;
    logic [2:0] op;
    logic [3:0] val;
    logic [3:0] pc;
    logic       busy, done;
    logic       chk_pc, chk_opval;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] val;
    logic [3:0] pc;
  } ins_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  ins_t ins_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] p_op[7]  = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [3:0] p_val[7] = '{4'd4, 4'd2, 4'd4, 4'd2, 4'd1, 4'd0, 4'd0};

  task automatic add(input logic r, input logic s, input logic a, input logic rdy,
                     input logic v, input logic [2:0] op, input logic [3:0] val,
                     input logic [3:0] p, input logic b, input logic d,
                     input logic cp, input logic co,
                     input logic we = 1'b0, input logic [3:0] wa = 4'd0,
                     input logic [2:0] wop = 3'd0, input logic [3:0] wval = 4'd0);
    vec_t t;
    t.rst_n = r; t.start = s; t.abort = a; t.ready = rdy;
    t.we = we; t.wa = wa; t.wop = wop; t.wval = wval;
    t.valid = v; t.op = op; t.val = val; t.pc = p; t.busy = b; t.done = d;
    t.chk_pc = cp; t.chk_opval = co;
    vecs.push_back(t);
  endtask

  task automatic add_start();
    add(1, 1, 0, 0, 1, p_op[0], p_val[0], 4'd0, 1, 0, 1, 0);
  endtask

  // One handshake at address p; optional ready=0 hold cycle afterwards, optional start or write riding along.
  task automatic add_step(input int p, input bit toggle, input logic st,
                          input logic we = 1'b0, input logic [2:0] wop = 3'd0,
                          input logic [3:0] wval = 4'd0);
    if (p < 6) begin
      add(1, st, 0, 1, 1, p_op[p+1], p_val[p+1], 4'(p+1), 1, 0, 1, 0, we, 4'd4, wop, wval);
      if (toggle) add(1, 0, 0, 0, 1, p_op[p+1], p_val[p+1], 4'(p+1), 1, 0, 1, 0);
    end else begin
      add(1, st, 0, 1, 0, 3'd0, 4'd0, 4'd6, 0, 1, 1, 0, we, 4'd4, wop, wval);
      add(1, 0, 0, 0, 0, 3'd0, 4'd0, 4'd6, 0, 0, 1, 0);
    end
  endtask

  task automatic add_full(input bit toggle);
    add_start();
    for (int p = 0; p < 7; p++) add_step(p, toggle, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      ins_t e;
      n_cmp++;
      if (ins_q.size() == 0) begin
        n_bad++;
        $display("FAIL issue: got op=%0d val=%0d pc=%0d, expected no handshake", instr_op, instr_val, pc);
      end else begin
        e = ins_q.pop_front();
        if (instr_op !== e.op || instr_val !== e.val || pc !== e.pc) begin
          n_bad++;
          $display("FAIL issue: got op=%0d val=%0d pc=%0d, want op=%0d val=%0d pc=%0d",
                   instr_op, instr_val, pc, e.op, e.val, e.pc);
        end
      end
    end
  end

  initial begin
    vec_t v, e, prev;
    bit   ok;

    // Reset and idle behaviour
    add(0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);
    // Back-to-back run, then ready toggling 1,0,1,0
    add_full(1'b0);
    add_full(1'b1);
    // Abort while pc=3 is presented, then a clean restart
    add_start();
    for (int p = 0; p < 3; p++) add_step(p, 1'b0, 1'b0);
    add(1, 0, 1, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, 0, 0);
    add_full(1'b0);
    // Start at pc=2 is ignored
    add_start();
    for (int p = 0; p < 7; p++) add_step(p, 1'b0, (p == 2) ? 1'b1 : 1'b0);
    add(1, 1, 1, 0, 0, 3'd0, 4'd0, 4'd6, 0, 0, 1, 0);
    // Reset while pc=5 is presented
    add_start();
    for (int p = 0; p < 5; p++) add_step(p, 1'b0, 1'b0);
    add(0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);
    add_full(1'b0);
`ifdef PROG_WR_EN
    add(1, 0, 0, 0, 0, 3'd0, 4'd0, 4'd6, 0, 0, 1, 0, 1'b1, 4'd4, 3'd2, 4'd7);
    p_op[4]  = 3'd2;
    p_val[4] = 4'd7;
    add_start();
    for (int p = 0; p < 7; p++) add_step(p, 1'b0, 1'b0, (p == 0) ? 1'b1 : 1'b0, 3'd5, 4'd5);
    add_full(1'b0);
`endif

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
`ifdef PROG_WR_EN
    prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_val = '0;
`endif
    prev = vecs[0];
    prev.valid = 1'b0;

    foreach (vecs[k]) begin
      v = vecs[k];
      rst_n = v.rst_n; start = v.start; abort = v.abort; instr_ready = v.ready;
`ifdef PROG_WR_EN
      prog_we = v.we; prog_addr = v.wa; prog_op = v.wop; prog_val = v.wval;
`endif
      if (prev.valid && v.ready && v.rst_n) begin
        ins_t ie;
        ie.op = prev.op; ie.val = prev.val; ie.pc = prev.pc;
        ins_q.push_back(ie);
      end
      exp_q.push_back(v);
      prev = v;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      ok = (instr_valid === e.valid) && (busy === e.busy) && (done === e.done);
      if (e.chk_pc && pc !== e.pc) ok = 1'b0;
      if ((e.valid || e.chk_opval) && (instr_op !== e.op || instr_val !== e.val)) ok = 1'b0;
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec%0d: got valid=%b pc=%0d op=%0d val=%0d busy=%b done=%b, want valid=%b pc=%0d op=%0d val=%0d busy=%b done=%b",
                 k, instr_valid, pc, instr_op, instr_val, busy, done,
                 e.valid, e.pc, e.op, e.val, e.busy, e.done);
      end
    end

    start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ins_q.size() != 0) begin
      n_bad++;
      $display("FAIL issue_count: %0d expected handshakes never seen, want 0", ins_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
